// File: rtl/wait_func_queue.sv
// -----------------------------------------------------------------------------
// wait_func_queue
//
// Pipelined, multi-outstanding wait function. Requests are accepted over an
// Avalon-ST style valid/ready handshake and queued with the timestamp at which
// they were taken. Requests retire strictly in issue order. Each result is the
// real number of cycles between acceptance and presentation of the result, so
// a short request stuck behind a long one reports its true elapsed time.
//
// Parameters
//   WIDTH  bit width of wait count, timestamp and result
//   DEPTH  maximum in-flight requests (power of 2, >= 2)
//
// Ports
//   CLK             clock
//   RST             synchronous active-high reset
//   m_input_value   requested wait w in cycles (clamped to 2^WIDTH-2)
//   m_valid_in      request valid
//   m_ready_out     request accept, registered, low while full
//   m_output_value  measured latency of the retired request
//   m_valid_out     result valid, registered
//   m_ready_in      downstream ready
//   m_occupancy     queued entries plus the output register
// -----------------------------------------------------------------------------
module wait_func_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           m_input_value,
  input  logic                       m_valid_in,
  output logic                       m_ready_out,
  output logic [WIDTH-1:0]           m_output_value,
  output logic                       m_valid_out,
  input  logic                       m_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] m_occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  // Largest wait that still lets the elapsed count (w+1) fit in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_WAIT = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);
  localparam logic [OW-1:0]    OCC_ONE  = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] now_q;
  logic [WIDTH-1:0] ts_mem   [DEPTH];
  logic [WIDTH-1:0] wait_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [OW-1:0]    count_q;
  logic             valid_q;
  logic [WIDTH-1:0] value_q;
  logic             ready_q;

  logic             accept;
  logic             head_eligible;
  logic             retire;
  logic             drain;
  logic [WIDTH-1:0] head_elapsed;
  logic [WIDTH-1:0] wait_clamped;
  logic [OW-1:0]    count_d;
  logic             valid_d;

  // Handshake decode and next-state of the queue count and output register.
  // The elapsed time is a modular difference, so the free-running counter
  // wrapping between accept and retire does not disturb eligibility.
  always_comb begin
    accept        = m_valid_in & ready_q;
    wait_clamped  = (m_input_value > MAX_WAIT) ? MAX_WAIT : m_input_value;
    head_elapsed  = now_q - ts_mem[rd_ptr_q];
    head_eligible = (count_q != '0) && (head_elapsed > wait_mem[rd_ptr_q]);
    retire        = head_eligible & (~valid_q | m_ready_in);
    drain         = valid_q & m_ready_in & ~retire;

    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + OCC_ONE;
    end else if (!accept && retire) begin
      count_d = count_q - OCC_ONE;
    end

    valid_d = valid_q;
    if (retire) begin
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Control state. ready is registered from the next occupancy so that it is
  // already low in the cycle in which the occupancy reads DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      now_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      value_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      now_q   <= now_q + ONE;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ((count_d + {{(OW-1){1'b0}}, valid_d}) != FULL_OCC);
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (retire) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        value_q  <= head_elapsed;
      end
    end
  end

  // Request storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (!RST && accept) begin
      ts_mem[wr_ptr_q]   <= now_q;
      wait_mem[wr_ptr_q] <= wait_clamped;
    end
  end

  assign m_ready_out    = ready_q;
  assign m_valid_out    = valid_q;
  assign m_output_value = value_q;
  assign m_occupancy    = count_q + {{(OW-1){1'b0}}, valid_q};

endmodule

// File: tb/tb_wait_func_queue.sv
// -----------------------------------------------------------------------------
// tb_wait_func_queue
//
// Bench for wait_func_queue. A 64-bit instance is checked every cycle against
// a queue-based reference model that works in absolute cycle numbers, plus
// directed scenarios with hand-computed expectations. An 8-bit instance is
// used for counter wrap-around and wait clamping.
// -----------------------------------------------------------------------------
module tb_wait_func_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;

  logic [63:0] m_input_value;
  logic        m_valid_in;
  logic        m_ready_out;
  logic [63:0] m_output_value;
  logic        m_valid_out;
  logic        m_ready_in;
  logic [2:0]  m_occupancy;

  logic [7:0]  w8;
  logic        v8;
  logic        ro8;
  logic [7:0]  val8;
  logic        vo8;
  logic        r8;
  logic [2:0]  occ8;

  int n_compared;
  int n_failed;

  wait_func_queue #(.WIDTH(64), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .m_input_value  (m_input_value),
    .m_valid_in     (m_valid_in),
    .m_ready_out    (m_ready_out),
    .m_output_value (m_output_value),
    .m_valid_out    (m_valid_out),
    .m_ready_in     (m_ready_in),
    .m_occupancy    (m_occupancy)
  );

  wait_func_queue #(.WIDTH(8), .DEPTH(DEPTH)) dut8 (
    .CLK            (CLK),
    .RST            (RST),
    .m_input_value  (w8),
    .m_valid_in     (v8),
    .m_ready_out    (ro8),
    .m_output_value (val8),
    .m_valid_out    (vo8),
    .m_ready_in     (r8),
    .m_occupancy    (occ8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison with counting and a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] w, input logic r);
    m_valid_in    = v;
    m_input_value = w;
    m_ready_in    = r;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each accepted request remembers the edge number at which
  // it was taken. The oldest one may leave once more edges than its wait have
  // passed and the output slot is free or being consumed.
  // ---------------------------------------------------------------------------
  typedef struct {
    longint unsigned acc;
    longint unsigned w;
  } req_t;

  req_t            mq[$];
  bit              m_init = 1'b0;
  bit              exp_valid;
  logic [63:0]     exp_value;
  bit              exp_ready;
  longint unsigned cyc = 0;

  function automatic longint unsigned clampWait(input longint unsigned w);
    if (w > 64'hFFFF_FFFF_FFFF_FFFE) return 64'hFFFF_FFFF_FFFF_FFFE;
    return w;
  endfunction

  always @(posedge CLK) begin : model
    bit   take;
    req_t r;
    cyc++;
    if (RST) begin
      mq.delete();
      exp_valid = 1'b0;
      exp_value = '0;
      exp_ready = 1'b1;
      m_init    = 1'b1;
    end else if (m_init) begin
      take = m_valid_in && exp_ready;
      if (mq.size() > 0 && (cyc - mq[0].acc) > mq[0].w && (!exp_valid || m_ready_in)) begin
        exp_value = cyc - mq[0].acc;
        exp_valid = 1'b1;
        void'(mq.pop_front());
      end else if (exp_valid && m_ready_in) begin
        exp_valid = 1'b0;
      end
      if (take) begin
        r.acc = cyc;
        r.w   = clampWait(m_input_value);
        mq.push_back(r);
      end
      exp_ready = ((mq.size() + int'(exp_valid)) != DEPTH);
    end
  end

  // Every-cycle comparison of the 64-bit instance against the model.
  always @(negedge CLK) begin
    if (m_init) begin
      checkOutput("model valid_out", {63'd0, m_valid_out}, {63'd0, exp_valid});
      checkOutput("model value_out", m_output_value, exp_value);
      checkOutput("model ready_out", {63'd0, m_ready_out}, {63'd0, exp_ready});
      checkOutput("model occupancy", {61'd0, m_occupancy},
                  64'(mq.size() + int'(exp_valid)));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic singleReq(input logic [63:0] w, input int n_wait,
                           input logic [63:0] expv, input string tag);
    applyStimulus(1'b1, w, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (n_wait) tick();
    checkOutput({tag, " early"}, {63'd0, m_valid_out}, 64'd0);
    tick();
    checkOutput({tag, " valid"}, {63'd0, m_valid_out}, 64'd1);
    checkOutput({tag, " value"}, m_output_value, expv);
    tick();
    checkOutput({tag, " drained"}, {63'd0, m_valid_out}, 64'd0);
  endtask

  task automatic singleReq8(input logic [7:0] w, input int n_wait,
                            input logic [7:0] expv, input string tag);
    v8 = 1'b1;
    w8 = w;
    tick();
    v8 = 1'b0;
    w8 = 8'd0;
    repeat (n_wait) tick();
    checkOutput({tag, " early"}, {63'd0, vo8}, 64'd0);
    tick();
    checkOutput({tag, " valid"}, {63'd0, vo8}, 64'd1);
    checkOutput({tag, " value"}, {56'd0, val8}, {56'd0, expv});
    tick();
    checkOutput({tag, " drained"}, {63'd0, vo8}, 64'd0);
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    RST = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    v8 = 1'b0;
    w8 = 8'd0;
    r8 = 1'b1;
    repeat (3) tick();
    RST = 1'b0;

    // Reset state
    checkOutput("reset ready_out", {63'd0, m_ready_out}, 64'd1);
    checkOutput("reset valid_out", {63'd0, m_valid_out}, 64'd0);
    checkOutput("reset value_out", m_output_value, 64'd0);
    checkOutput("reset occupancy", {61'd0, m_occupancy}, 64'd0);
    checkOutput("reset8 ready_out", {63'd0, ro8}, 64'd1);

    // Single requests: w=0 gives 1, w=10 gives 11
    $display("[TB] single requests");
    singleReq(64'd0, 0, 64'd1, "t1 w0");
    singleReq(64'd10, 10, 64'd11, "t1 w10");

    // Four back-to-back w=5; extra requests while full are ignored
    $display("[TB] back-to-back fill");
    for (int i = 0; i <= 11; i++) begin
      if (i <= 3)      applyStimulus(1'b1, 64'd5, 1'b1);
      else if (i <= 6) applyStimulus(1'b1, 64'd0, 1'b1);
      else             applyStimulus(1'b0, 64'd0, 1'b1);
      if (i <= 3)            checkOutput("t2 ready before full", {63'd0, m_ready_out}, 64'd1);
      if (i >= 4 && i <= 7)  checkOutput("t2 ready while full", {63'd0, m_ready_out}, 64'd0);
      if (i == 4)            checkOutput("t2 occupancy full", {61'd0, m_occupancy}, 64'd4);
      if (i == 8)            checkOutput("t2 ready reasserted", {63'd0, m_ready_out}, 64'd1);
      if (i >= 7 && i <= 10) begin
        checkOutput("t2 result valid", {63'd0, m_valid_out}, 64'd1);
        checkOutput("t2 result value", m_output_value, 64'd6);
      end
      if (i == 11) begin
        checkOutput("t2 final valid", {63'd0, m_valid_out}, 64'd0);
        checkOutput("t2 final occupancy", {61'd0, m_occupancy}, 64'd0);
      end
      tick();
    end

    // In-order completion: w=20 then w=2
    $display("[TB] in-order completion");
    applyStimulus(1'b1, 64'd20, 1'b1);
    tick();
    applyStimulus(1'b1, 64'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (19) tick();
    checkOutput("t3 early", {63'd0, m_valid_out}, 64'd0);
    tick();
    checkOutput("t3 first valid", {63'd0, m_valid_out}, 64'd1);
    checkOutput("t3 first value", m_output_value, 64'd21);
    tick();
    checkOutput("t3 second valid", {63'd0, m_valid_out}, 64'd1);
    checkOutput("t3 second value", m_output_value, 64'd21);
    tick();
    checkOutput("t3 drained", {63'd0, m_valid_out}, 64'd0);

    // Output stall: w=3 with downstream not ready for ten cycles
    $display("[TB] output stall");
    applyStimulus(1'b1, 64'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("t4 occupancy", {61'd0, m_occupancy}, 64'd1);
      if (i < 5) begin
        checkOutput("t4 early", {63'd0, m_valid_out}, 64'd0);
      end else begin
        checkOutput("t4 held valid", {63'd0, m_valid_out}, 64'd1);
        checkOutput("t4 held value", m_output_value, 64'd4);
      end
      tick();
    end
    checkOutput("t4 dropped valid", {63'd0, m_valid_out}, 64'd0);
    checkOutput("t4 final occupancy", {61'd0, m_occupancy}, 64'd0);

    // Reset with three requests in flight
    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'd30, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    tick();
    tick();
    checkOutput("t6 occupancy before", {61'd0, m_occupancy}, 64'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("t6 valid after", {63'd0, m_valid_out}, 64'd0);
    checkOutput("t6 occupancy after", {61'd0, m_occupancy}, 64'd0);
    checkOutput("t6 ready after", {63'd0, m_ready_out}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("t6 no stale result", {63'd0, m_valid_out}, 64'd0);
    end

    // Randomized traffic with occasional resets, checked by the model
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 399) == 0);
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? {32'd0, $urandom_range(0, 25)}
                                                : {32'd0, $urandom_range(0, 3)},
                    ($urandom_range(0, 3) != 0));
      tick();
    end
    RST = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (200) tick();

    // 8-bit instance: counter wrap and wait clamping
    $display("[TB] wrap-around and clamp");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (250) tick();
    singleReq8(8'd10, 10, 8'd11, "t5 wrap w10");
    singleReq8(8'd255, 254, 8'd255, "t5 clamp w255");
    checkOutput("t5 occupancy", {61'd0, occ8}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
